pe_instr_decoder: RTL and testbench

- Per-PE receive end of the tile-control instruction stream produced by the FW control unit.
- Registers each `{fwd, id, op}` instruction and its data beat, then forwards both one cycle later to the next PE in the daisy chain.
- Decodes whether the instruction targets this PE and turns it into local buffer read/write strobes, beat addresses and process enables.
- Sits between the control unit (or the upstream PE) and the PE's row/column buffers and min-plus datapath.

---
 rtl/pe_instr_decoder_pkg.sv | 43 ++++
 rtl/pe_beat_counter.sv | 33 +++
 rtl/pe_instr_decoder.sv | 124 ++++++++++++
 tb/tb_pe_instr_decoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pe_instr_decoder_pkg.sv
// Shared tile/beat geometry, opcode encodings and instruction layout for the PE decoder.
// Latency: n/a (types and constants only). Backpressure: n/a.
package pe_instr_decoder_pkg;

  localparam int B           = 16;
  localparam int L           = 4;
  localparam int WIDTH       = 8;
  localparam int logB        = 4;
  localparam int logL        = 2;
  localparam int OP_WIDTH    = 3;
  localparam int INSTR_WIDTH = 1 + logB + OP_WIDTH;
  localparam int DATA_W      = L * WIDTH;
  localparam int BEATS       = B / L;
  localparam int CNT_W       = logB - logL;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [OP_WIDTH-1:0] OP_READ_ROW    = 3'b000;
  localparam logic [OP_WIDTH-1:0] OP_READ_COL    = 3'b001;
  localparam logic [OP_WIDTH-1:0] OP_SEND_ROW    = 3'b010;
  localparam logic [OP_WIDTH-1:0] OP_SEND_COL    = 3'b011;
  localparam logic [OP_WIDTH-1:0] OP_PROCESS_ROW = 3'b100;
  localparam logic [OP_WIDTH-1:0] OP_IDLE        = 3'b111;

  typedef enum logic [1:0] {
    SELF_DEP   = 2'd0,
    DOUBLY_DEP = 2'd1,
    ROW_DEP    = 2'd2,
    COL_DEP    = 2'd3
  } dep_t;

  typedef struct packed {
    logic                fwd;
    logic [logB-1:0]     id;
    logic [OP_WIDTH-1:0] op;
  } instr_t;

  // 101 and 110 are the only unassigned codes.
  function automatic logic op_legal(input logic [OP_WIDTH-1:0] op);
    return (op <= OP_PROCESS_ROW) || (op == OP_IDLE);
  endfunction

endpackage

// File: rtl/pe_beat_counter.sv
// Mod-B/L beat position within the current (op, id) run; holds on stall, restarts at 0 on a new run.
// Latency: addr is combinational from count/restart. Backpressure: none, stall is the only hold.
module pe_beat_counter
  import pe_instr_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             restart,
  output logic [CNT_W-1:0] addr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_nxt;

  assign addr = restart ? '0 : count;

  always_comb begin
    count_nxt = count;
    if (!stall) begin
      count_nxt = (addr == LAST_BEAT) ? '0 : addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/pe_instr_decoder.sv
// Per-PE instruction receiver: forwards {instr, data} down the chain and decodes local buffer strobes.
// Latency: 1 cycle for pass-through and all strobes. Backpressure: none, one instruction per cycle.
module pe_instr_decoder
  import pe_instr_decoder_pkg::*;
#(
  parameter int unsigned PE_ID = 0
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [DATA_W-1:0]      dIn,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [DATA_W-1:0]      dOut,
  output logic                   row_we,
  output logic                   col_we,
  output logic [CNT_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   rd_row,
  output logic                   rd_col,
  output logic                   proc_en,
  output logic [CNT_W-1:0]       rd_addr,
  output logic                   fwd_en,
  output logic                   phase_done,
  output logic                   err
);

  instr_t              ins;
  logic [OP_WIDTH-1:0] prev_op;
  logic [logB-1:0]     prev_id;
  logic [CNT_W-1:0]    beat_addr;
  logic [CNT_W-1:0]    beat_count;
  logic                idle;
  logic                legal;
  logic                active;
  logic                same_run;
  logic                match;
  logic                is_read;
  logic                is_sweep;
  logic                last_beat_q;

  assign ins      = instr_t'(instr_in);
  assign idle     = (ins.op == OP_IDLE);
  assign legal    = op_legal(ins.op);
  assign active   = legal && !idle;
  assign same_run = (ins.op == prev_op) && (ins.id == prev_id);
  assign match    = (ins.id == logB'(PE_ID)) && !idle;
  assign is_read  = (ins.op == OP_READ_ROW) || (ins.op == OP_READ_COL);
  assign is_sweep = (ins.op == OP_SEND_ROW) || (ins.op == OP_SEND_COL) ||
                    (ins.op == OP_PROCESS_ROW);

  // Illegal opcodes stall the counter like IDLE so a bad word cannot shift beat alignment.
  pe_beat_counter u_beat_counter (
    .clk     (clk),
    .reset   (reset),
    .stall   (!active),
    .restart (!same_run),
    .addr    (beat_addr),
    .count   (beat_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_out <= {1'b0, logB'(0), OP_IDLE};
      dOut      <= '1;
      wr_data   <= '0;
    end else begin
      instr_out <= instr_in;
      dOut      <= dIn;
      wr_data   <= dIn;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_op <= OP_IDLE;
      prev_id <= '0;
    end else if (active) begin
      prev_op <= ins.op;
      prev_id <= ins.id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_we      <= 1'b0;
      col_we      <= 1'b0;
      rd_row      <= 1'b0;
      rd_col      <= 1'b0;
      proc_en     <= 1'b0;
      fwd_en      <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      last_beat_q <= 1'b0;
      phase_done  <= 1'b0;
    end else begin
      row_we      <= active && match && (ins.op == OP_READ_ROW);
      col_we      <= active && match && (ins.op == OP_READ_COL);
      rd_row      <= active && match && (ins.op == OP_SEND_ROW);
      rd_col      <= active && match && (ins.op == OP_SEND_COL);
      proc_en     <= active && (ins.op == OP_PROCESS_ROW);
      fwd_en      <= active && match && is_read && ins.fwd;
      if (active && match && is_read) begin
        wr_addr <= beat_addr;
      end
      if (active && is_sweep) begin
        rd_addr <= beat_addr;
      end
      // Extra stage puts phase_done one cycle behind the final beat's strobe.
      last_beat_q <= active && is_sweep && (ins.id == logB'(B - 1)) &&
                     (beat_addr == LAST_BEAT);
      phase_done  <= last_beat_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (!legal || (active && !same_run && (beat_count != '0))) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_instr_decoder.sv
// Directed table-driven bench for pe_instr_decoder (PE_ID=3) plus hand-written reset/error sequences.
module tb_pe_instr_decoder;
  import pe_instr_decoder_pkg::*;

  localparam int unsigned PE = 3;

  localparam logic [7:0] S_ROW_WE = 8'h80;
  localparam logic [7:0] S_COL_WE = 8'h40;
  localparam logic [7:0] S_RD_ROW = 8'h20;
  localparam logic [7:0] S_PROC   = 8'h08;
  localparam logic [7:0] S_FWD    = 8'h04;
  localparam logic [7:0] S_PD     = 8'h02;
  localparam logic [7:0] S_ERR    = 8'h01;

  typedef struct {
    logic [INSTR_WIDTH-1:0] ins;
    logic [DATA_W-1:0]      din;
    logic [7:0]             strb;
    logic [CNT_W-1:0]       wa;
    logic [CNT_W-1:0]       ra;
  } vec_t;

  vec_t vecs[$];

  logic                   clk;
  logic                   reset;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic [DATA_W-1:0]      dIn;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [DATA_W-1:0]      dOut;
  logic                   row_we, col_we, rd_row, rd_col, proc_en, fwd_en, phase_done, err;
  logic [CNT_W-1:0]       wr_addr, rd_addr;
  logic [DATA_W-1:0]      wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  pe_instr_decoder #(.PE_ID(PE)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_in   (instr_in),
    .dIn        (dIn),
    .instr_out  (instr_out),
    .dOut       (dOut),
    .row_we     (row_we),
    .col_we     (col_we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .proc_en    (proc_en),
    .rd_addr    (rd_addr),
    .fwd_en     (fwd_en),
    .phase_done (phase_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSTR_WIDTH-1:0] mk(input logic f, input int id,
                                                input logic [OP_WIDTH-1:0] op);
    return {f, logB'(id), op};
  endfunction

  function automatic logic [7:0] strobes();
    return {row_we, col_we, rd_row, rd_col, proc_en, fwd_en, phase_done, err};
  endfunction

  task automatic add(input logic [INSTR_WIDTH-1:0] ins, input int din, input logic [7:0] strb,
                     input int wa, input int ra);
    vec_t v;
    v.ins  = ins;
    v.din  = DATA_W'(din);
    v.strb = strb;
    v.wa   = CNT_W'(wa);
    v.ra   = CNT_W'(ra);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic [INSTR_WIDTH-1:0] ins, input logic [DATA_W-1:0] d);
    instr_in = ins;
    dIn      = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [INSTR_WIDTH-1:0] idle_w;
    idle_w = mk(1'b0, 0, OP_IDLE);

    // Reset release, then idle cycles.
    for (int i = 0; i < 8; i++) add(idle_w, 32'h100 + i, 8'h00, 0, 0);
    // READ_ROW id=3 four beats.
    for (int b = 0; b < 4; b++) add(mk(1'b0, 3, OP_READ_ROW), b + 1, S_ROW_WE, b, 0);
    // READ_ROW id=2 targets another PE.
    for (int b = 0; b < 4; b++) add(mk(1'b0, 2, OP_READ_ROW), 32'h20 + b, 8'h00, 3, 0);
    // READ_ROW id=3 split by two IDLE stalls.
    add(mk(1'b0, 3, OP_READ_ROW), 32'h31, S_ROW_WE, 0, 0);
    add(mk(1'b0, 3, OP_READ_ROW), 32'h32, S_ROW_WE, 1, 0);
    add(idle_w, 32'h0, 8'h00, 1, 0);
    add(idle_w, 32'h0, 8'h00, 1, 0);
    add(mk(1'b0, 3, OP_READ_ROW), 32'h33, S_ROW_WE, 2, 0);
    add(mk(1'b0, 3, OP_READ_ROW), 32'h34, S_ROW_WE, 3, 0);
    // Full SEND_ROW sweep.
    for (int id = 0; id < B; id++)
      for (int b = 0; b < BEATS; b++)
        add(mk(1'b0, id, OP_SEND_ROW), id * 16 + b, (id == PE) ? S_RD_ROW : 8'h00, 3, b);
    add(idle_w, 32'h0, S_PD, 3, 3);
    add(idle_w, 32'h0, 8'h00, 3, 3);
    // PROCESS_ROW id=15 acts on every PE and closes a phase.
    for (int b = 0; b < BEATS; b++) add(mk(1'b0, 15, OP_PROCESS_ROW), 32'h500 + b, S_PROC, 3, b);
    add(idle_w, 32'h0, S_PD, 3, 3);
    // READ_COL id=3 with fwd.
    for (int b = 0; b < BEATS; b++) add(mk(1'b1, 3, OP_READ_COL), 32'hC0 + b, S_COL_WE | S_FWD, b, 3);
    // READ_ROW id=15 last beat: no phase_done.
    for (int b = 0; b < BEATS; b++) add(mk(1'b0, 15, OP_READ_ROW), 32'hF0 + b, 8'h00, 3, 3);
    add(idle_w, 32'h0, 8'h00, 3, 3);
    // Illegal opcode: sticky err, no strobes.
    add(mk(1'b0, 3, 3'b101), 32'hBAD, S_ERR, 3, 3);
    add(idle_w, 32'h0, S_ERR, 3, 3);

    reset    = 1'b1;
    instr_in = idle_w;
    dIn      = '0;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_instr_out", -1, 32'(instr_out), 32'(idle_w));
    chk("rst_dout", -1, 32'(dOut), 32'hFFFF_FFFF);
    chk("rst_strobes", -1, 32'(strobes()), 32'h0);
    chk("rst_addrs", -1, 32'({wr_addr, rd_addr}), 32'h0);
    reset = 1'b1;
    #1;
    chk("release_dout", -1, 32'(dOut), 32'hFFFF_FFFF);

    foreach (vecs[i]) begin
      step(vecs[i].ins, vecs[i].din);
      chk("instr_out", i, 32'(instr_out), 32'(vecs[i].ins));
      chk("dout", i, 32'(dOut), 32'(vecs[i].din));
      chk("wr_data", i, 32'(wr_data), 32'(vecs[i].din));
      chk("strobes", i, 32'(strobes()), 32'(vecs[i].strb));
      chk("wr_addr", i, 32'(wr_addr), 32'(vecs[i].wa));
      chk("rd_addr", i, 32'(rd_addr), 32'(vecs[i].ra));
    end

    // Async reset clears sticky err without a clock edge.
    #2 reset = 1'b0;
    #1;
    chk("arst_err", 1000, 32'(err), 32'h0);
    chk("arst_strobes", 1000, 32'(strobes()), 32'h0);
    chk("arst_dout", 1000, 32'(dOut), 32'hFFFF_FFFF);
    @(posedge clk);
    #1 reset = 1'b1;

    // READ_ROW cut short by READ_COL flags err.
    step(mk(1'b0, 3, OP_READ_ROW), 32'h41);
    chk("cut_b0", 1001, 32'({strobes(), 6'(wr_addr)}), 32'({S_ROW_WE, 6'd0}));
    step(mk(1'b0, 3, OP_READ_ROW), 32'h42);
    chk("cut_b1", 1002, 32'({strobes(), 6'(wr_addr)}), 32'({S_ROW_WE, 6'd1}));
    step(mk(1'b0, 3, OP_READ_COL), 32'h43);
    chk("cut_switch", 1003, 32'({strobes(), 6'(wr_addr)}), 32'({S_COL_WE | S_ERR, 6'd0}));
    step(mk(1'b0, 3, OP_READ_COL), 32'h44);
    chk("cut_next", 1004, 32'({strobes(), 6'(wr_addr)}), 32'({S_COL_WE | S_ERR, 6'd1}));

    // Mid-run reset: the next READ_ROW restarts at beat 0.
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_err", 1005, 32'(err), 32'h0);
    chk("mid_rst_wr_addr", 1005, 32'(wr_addr), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(mk(1'b0, 3, OP_READ_ROW), 32'h51);
    chk("after_rst_b0", 1006, 32'({strobes(), 6'(wr_addr)}), 32'({S_ROW_WE, 6'd0}));
    step(mk(1'b0, 3, OP_READ_ROW), 32'h52);
    chk("after_rst_b1", 1007, 32'({strobes(), 6'(wr_addr)}), 32'({S_ROW_WE, 6'd1}));
    chk("after_rst_wr_data", 1007, 32'(wr_data), 32'h52);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
